// File: rtl/altavoz_pkg.sv
// rtl/altavoz_pkg.sv - shared defaults and width helpers for the altavoz I2S transmitter
package altavoz_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_BCLK_DIV = 2;

    // Counters never shrink below one bit, even when the range collapses to a single value.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DIV_W = width_of(DEF_BCLK_DIV);
    localparam int DEF_CNT_W = width_of(DEF_DATA_W);

endpackage

// File: rtl/altavoz_bclk_gen.sv
// rtl/altavoz_bclk_gen.sv - bit clock divider with rise/fall strobes
module altavoz_bclk_gen
    import altavoz_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = width_of(BCLK_DIV);

    logic [DIV_W-1:0] div;
    logic             tick;

    assign tick = run && (div == DIV_W'(BCLK_DIV - 1));

    // Strobes flag the edge on which bclk is about to change, so the top can move data on that same edge.
    assign rise = tick && !bclk;
    assign fall = tick && bclk;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (tick) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div  <= div + 1'b1;
        end
    end

endmodule

// File: rtl/altavoz_i2s_tx.sv
// rtl/altavoz_i2s_tx.sv - mono PCM to I2S serialiser for the speaker DAC
module altavoz_i2s_tx
    import altavoz_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sregt,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              done
);

    localparam int CNT_W = width_of(DATA_W);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bitcnt;
    logic              running;
    logic              lrclk_q;
    logic              done_q;
    logic              fall;
    logic              unused_rise;

    altavoz_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk   (clk),
        .reset (reset),
        .run   (running && enable),
        .bclk  (bclk),
        .rise  (unused_rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            shreg   <= '0;
            bitcnt  <= '0;
            running <= 1'b0;
            lrclk_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (!running) begin
            shreg   <= sregt;
            bitcnt  <= '0;
            running <= 1'b1;
            lrclk_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fall) begin
                if (bitcnt == CNT_W'(DATA_W - 1)) begin
                    // Slot end: latch the next sample and swap channel in one step.
                    shreg   <= sregt;
                    bitcnt  <= '0;
                    lrclk_q <= ~lrclk_q;
                    done_q  <= 1'b1;
                end else begin
                    shreg  <= {shreg[DATA_W-2:0], 1'b0};
                    bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

    assign sdata = shreg[DATA_W-1];
    assign lrclk = lrclk_q;
    assign done  = done_q;

endmodule

// File: tb/tb_altavoz_i2s_tx.sv
// tb/tb_altavoz_i2s_tx.sv - scoreboard bench for altavoz_i2s_tx
module tb_altavoz_i2s_tx;

    typedef struct packed {
        int   c;
        logic lr;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        en1 = 1'b0;
    logic [15:0] sregt = 16'h0000;
    logic        bclk, lrclk, sdata, done;
    logic        bclk1, lrclk1, sdata1, done1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int s = 0;
    logic prev_bclk = 1'b0;

    logic [1:0] bq[$];
    done_exp_t  dq[$];
    done_exp_t  d1q[$];

    altavoz_i2s_tx dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .sregt  (sregt),
        .bclk   (bclk),
        .lrclk  (lrclk),
        .sdata  (sdata),
        .done   (done)
    );

    altavoz_i2s_tx #(.DATA_W(16), .BCLK_DIV(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .enable (en1),
        .sregt  (sregt),
        .bclk   (bclk1),
        .lrclk  (lrclk1),
        .sdata  (sdata1),
        .done   (done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input logic lr, input int nbits);
        logic [15:0] v;
        v = w;
        for (int i = 15; i > 15 - nbits; i--) bq.push_back({lr, v[i]});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_outs"}, {28'd0, bclk, lrclk, sdata, done}, 32'd0);
    endtask

    // Monitor: bit scoreboard at each bclk rise, done scoreboards on every done pulse.
    always @(negedge clk) begin
        logic [1:0] e;
        done_exp_t  d;
        if (bclk === 1'b1 && prev_bclk === 1'b0) begin
            if (bq.size() == 0) begin
                check("bit_unexpected", 32'd1, 32'd0);
            end else begin
                e = bq.pop_front();
                check("sdata_at_rise", {31'd0, sdata}, {31'd0, e[0]});
                check("lrclk_at_rise", {31'd0, lrclk}, {31'd0, e[1]});
            end
        end
        prev_bclk = bclk;
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                check("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                d = dq.pop_front();
                check("done_cycle", 32'(cyc), 32'(d.c));
                check("done_lrclk", {31'd0, lrclk}, {31'd0, d.lr});
            end
        end
        if (done1 === 1'b1) begin
            if (d1q.size() == 0) begin
                check("done1_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                d = d1q.pop_front();
                check("done1_cycle", 32'(cyc), 32'(d.c));
                check("done1_lrclk", {31'd0, lrclk1}, {31'd0, d.lr});
            end
        end
    end

    initial begin
        // Reset held with enable high
        @(negedge clk);
        reset = 1'b1; enable = 1'b1; sregt = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset");
        end

        // Serialisation, slot boundary and sample change mid-slot
        reset = 1'b0; enable = 1'b0;
        @(negedge clk);
        sregt = 16'h512A; enable = 1'b1; s = cyc + 1;
        push_word(16'h512A, 1'b0, 16);
        push_word(16'hFFFF, 1'b1, 16);
        push_word(16'hFFFF, 1'b0, 1);
        dq.push_back('{c: s + 64, lr: 1'b1});
        dq.push_back('{c: s + 128, lr: 1'b0});
        @(negedge clk);
        check("bclk_low_after_start", {31'd0, bclk}, 32'd0);
        check("sdata_msb_at_start", {31'd0, sdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("first_rise_at_2", {31'd0, bclk}, 32'd1);
        wait_until(s + 30);
        sregt = 16'hFFFF;
        wait_until(s + 132);
        enable = 1'b0;
        @(negedge clk);
        check_idle("disable");
        check("bits_drained_1", 32'(bq.size()), 32'd0);

        // Abort mid-word, then restart from the MSB
        sregt = 16'hA5C3; enable = 1'b1; s = cyc + 1;
        push_word(16'hA5C3, 1'b0, 5);
        wait_until(s + 20);
        enable = 1'b0;
        @(negedge clk);
        check_idle("abort");
        sregt = 16'h8001; enable = 1'b1; s = cyc + 1;
        push_word(16'h8001, 1'b0, 16);
        push_word(16'h8001, 1'b1, 2);
        dq.push_back('{c: s + 64, lr: 1'b1});

        // Reset mid-operation, released with enable still high
        wait_until(s + 70);
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        reset = 1'b0; sregt = 16'h3C00; s = cyc + 1;
        push_word(16'h3C00, 1'b0, 5);
        wait_until(s + 20);
        enable = 1'b0;
        @(negedge clk);
        check("bits_drained_2", 32'(bq.size()), 32'd0);
        check("done_drained", 32'(dq.size()), 32'd0);

        // BCLK_DIV=1 instance: 2-clk bit period, slot of 32 clk
        en1 = 1'b1; s = cyc + 1;
        d1q.push_back('{c: s + 32, lr: 1'b1});
        d1q.push_back('{c: s + 64, lr: 1'b0});
        @(negedge clk);
        check("div1_bclk_start", {31'd0, bclk1}, 32'd0);
        @(negedge clk);
        check("div1_bclk_rise", {31'd0, bclk1}, 32'd1);
        @(negedge clk);
        check("div1_bclk_fall", {31'd0, bclk1}, 32'd0);
        wait_until(s + 66);
        en1 = 1'b0;
        @(negedge clk);
        check("div1_idle", {29'd0, bclk1, lrclk1, sdata1}, 32'd0);
        repeat (4) @(negedge clk);
        check("done1_drained", 32'(d1q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/altavoz_i2s_tx.md
Name: altavoz_i2s_tx

Overview:
- Serial audio transmitter driving the speaker-side DAC (altavoz) in the PCM audio path.
- Takes a 16-bit parallel PCM sample (sregt) and serialises it MSB-first on sdata, with a generated bit clock (bclk) and left/right word clock (lrclk).
- Mono: the same sample is sent in both the left and right slots.
- Sits between the sample source (mic/PCM buffer) and the external DAC pins.

Parameters:
- DATA_W, 16, sample width and bits per channel slot.
- BCLK_DIV, 2, clk cycles per bclk half-period; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = transmit; 0 = idle.
- sregt  input  DATA_W  parallel PCM sample; sampled only at slot start.
- bclk  output  1  serial bit clock, 50% duty, period 2*BCLK_DIV clk.
- lrclk  output  1  word select: 0 = left slot, 1 = right slot.
- sdata  output  1  serial data, MSB first, changes only on bclk falling transitions.
- done  output  1  one-clk pulse when a slot completes and the next sample is latched.

Behaviour:
- One clock domain (clk); reset is synchronous, active-high. All outputs are registered.
- Reset (reset=1 at a clk edge): bclk=0, lrclk=0, sdata=0, done=0.
  - Internal divider count, bit count, shift register and running flag all = 0.
  - Reset has priority over enable.
- Idle (enable=0): on the next clk edge, enter the reset-equivalent state (same values as reset).
  - Deasserting enable mid-word aborts the word; no done pulse is generated.
- Start: the first clk edge with enable=1 while idle:
  - load shift register from sregt; sdata=sregt[DATA_W-1];
  - lrclk=0, bclk=0, div=0, bitcnt=0, running=1;
  - done stays 0.
- Running:
  - div increments every clk. On div==BCLK_DIV-1, div wraps to 0 and bclk toggles.
  - bclk 0->1 transition: no data change; this is the receiver sample point.
  - bclk 1->0 transition, bitcnt<DATA_W-1: shift left; sdata=next bit; bitcnt++.
  - bclk 1->0 transition, bitcnt==DATA_W-1 (slot end):
    - reload shift register from the current sregt; sdata=sregt[DATA_W-1];
    - bitcnt=0; lrclk toggles;
    - done=1 for exactly that one clk cycle.
- Timing with defaults: bit period 4 clk, slot 64 clk, frame 128 clk.
  - First bclk rise is 2 clk after start.
  - First done and first lrclk toggle occur 64 clk after start.
- done is 0 at all times other than the slot-end cycle.
- sregt changes between slot starts have no effect on the word in flight.
- sregt is don't-care while idle.

Decomposition:
- Package altavoz_pkg holds DATA_W and BCLK_DIV defaults, plus the divider and bit-counter widths computed via $clog2.
- Sub-module altavoz_bclk_gen contains the divider and bclk toggle, and outputs one-clk rise/fall strobes.
- The top level holds the shift register, bit counter, lrclk and done.

Test Plan:
- Reset: hold reset=1 for 3 clk with enable=1 -> bclk=lrclk=sdata=done=0 throughout.
- Serialisation: sregt=16'h512A, enable 0->1 -> sdata at bclk rises = 0,1,0,1,0,0,0,1,0,0,1,0,1,0,1,0.
  - First bclk rise is 2 clk after start; lrclk=0 for the whole slot.
- Slot boundary: keep enable=1, change sregt to 16'hFFFF at clk 30 after start.
  - At clk 64: done=1 for one cycle and lrclk=1.
  - The left slot is still 16'h512A; the right slot sends 16'hFFFF.
  - At clk 128: done pulses again and lrclk=0.
- Abort: drop enable at clk 20 after start -> next cycle all outputs 0 and no done pulse.
  - Re-enable -> restart from the MSB with lrclk=0.
- Reset mid-operation: assert reset at clk 70 -> next edge all outputs 0.
  - Releasing reset with enable=1 restarts as for Start.
- Parameter: BCLK_DIV=1 -> bclk period 2 clk; done at clk 32 and clk 64 after start.
